lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_req_valid, input, 1, pipeline access request.
REQ-004 SHALL have port o_req_ready, output, 1, request accepted when high with i_req_valid.
REQ-005 SHALL have port i_req_store, input, 1, 1=store, 0=load.
REQ-006 SHALL have port i_req_size, input, 2, 0=byte, 1=half, 2=word, 3=illegal.
REQ-007 SHALL have port i_req_unsigned, input, 1, zero-extend load result when high.
REQ-008 SHALL have ports i_req_addr and i_req_wdata, input, 32 each, byte address and store data (LSB-justified).
REQ-009 SHALL have ports o_mem_valid (1), o_mem_we (1), o_mem_addr (32, word-aligned), o_mem_mask (32, bit mask), o_mem_wdata (32), all outputs.
REQ-010 SHALL have ports i_mem_ready (1) and i_mem_rdata (32), inputs; rdata valid in ready cycle.
REQ-011 SHALL have ports o_rsp_valid (1), o_rsp_data (32), o_rsp_err (1) outputs and i_rsp_ready (1) input.

Function
REQ-012 SHALL implement states IDLE, ACC0, ACC1, RESP; o_req_ready = 1 only in IDLE.
REQ-013 SHALL on accept latch store, size, unsigned, addr, wdata; byte index bi = addr[1:0]; size mask 0xff/0xffff/0xffffffff.
REQ-014 SHALL classify access misaligned when size=1 and bi=3, or size=2 and bi!=0.
REQ-015 SHALL on accept go to RESP with o_rsp_err=1, o_rsp_data=0, no memory access, when size=3 or (misaligned and MISALIGNED_EN undefined); otherwise go to ACC0.
REQ-016 SHALL in ACC0 drive o_mem_valid=1, o_mem_addr = addr & ~3, o_mem_mask = (size mask << 8*bi) truncated to 32 bits, o_mem_wdata = wdata << 8*bi, o_mem_we = store.
REQ-017 SHALL hold all o_mem_* stable while o_mem_valid=1 and i_mem_ready=0.
REQ-018 SHALL in ACC0 on i_mem_ready capture rdata into a 32-bit buffer and go to ACC1 if misaligned, else RESP.
REQ-019 SHALL in ACC1 drive o_mem_addr = (addr & ~3) + 4 (wrapping modulo 2^32), o_mem_mask = size mask >> (32 - 8*bi), o_mem_wdata = wdata >> (32 - 8*bi); on i_mem_ready go to RESP.
REQ-020 SHALL form load raw data = (buf >> 8*bi) | (rdata1 << (32 - 8*bi)) for split accesses, buf >> 8*bi otherwise; then mask to size and sign-extend from bit 7/15 unless unsigned.
REQ-021 SHALL in RESP assert o_rsp_valid, hold o_rsp_data/o_rsp_err stable until i_rsp_ready, then go to IDLE; stores respond with data 0, err 0.
REQ-022 SHALL give aligned latency: accept cycle N, o_mem_valid from N+1, o_rsp_valid earliest N+2 (zero-wait memory); split adds one cycle.
REQ-023 SHALL accept no new request before response handshake completes (one outstanding access).
REQ-024 SHALL drive o_mem_valid=0, o_mem_mask=0 outside ACC0/ACC1.

Reset
REQ-025 SHALL on i_rst, at any time including mid-access, force IDLE, o_mem_valid=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0, buffers 0; abandoned memory transaction not retried.
REQ-026 SHALL assert o_req_ready=1 in first cycle after i_rst deasserts.

Configuration
REQ-027 SHALL, with macro LSU_MISALIGNED_EN defined, execute misaligned accesses as ACC0+ACC1 split per REQ-018..020.
REQ-028 SHALL, without LSU_MISALIGNED_EN, omit ACC1 logic and return misaligned accesses as error per REQ-015.

Verification
REQ-029 SHALL cover load byte addr 0x1003, rdata 0x80AABBCC, signed -> mem addr 0x1000 mask 0xFF000000, rsp 0xFFFFFF80, rsp_valid at cycle N+2.
REQ-030 SHALL cover store half addr 0x2002 wdata 0x1234 -> addr 0x2000, mask 0xFFFF0000, wdata 0x12340000, we=1, rsp err 0.
REQ-031 SHALL cover (LSU_MISALIGNED_EN) load word addr 0x3001, rdata0 0x44332211, rdata1 0x88776655 -> accesses 0x3000 mask 0xFFFFFF00 then 0x3004 mask 0x000000FF, rsp 0x55443322.
REQ-032 SHALL cover (no LSU_MISALIGNED_EN) load word addr 0x3002, and size=3 at 0x0 -> no o_mem_valid, rsp err 1 data 0.
REQ-033 SHALL cover i_mem_ready held low 5 cycles and i_rsp_ready low 3 cycles -> mem outputs and response stable, o_req_ready 0 throughout.
REQ-034 SHALL cover i_rst asserted during ACC0 wait -> o_mem_valid 0 same cycle asynchronously, no response, o_req_ready 1 after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit front end.
// Converts byte/half/word requests into word-aligned memory accesses with
// byte-lane masks, and returns sign/zero-extended load data.
// Optional macro LSU_MISALIGNED_EN: split misaligned accesses into two
// word accesses (ACC0 + ACC1); without it they are answered with an error.
module lsu_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_valid,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_mask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    input  logic        i_rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef LSU_MISALIGNED_EN
    logic [31:0] buf_q, buf_d;
`endif

    // Access crosses a word boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] bi);
        return ((size == 2'd1) && (bi == 2'd3)) || ((size == 2'd2) && (bi != 2'd0));
    endfunction

    // Mask raw load bytes to the access size and extend to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] size,
                                             input logic uns);
        case (size)
            2'd0:    return {{24{~uns & raw[7]}}, raw[7:0]};
            2'd1:    return {{16{~uns & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    logic [4:0]  sh;
    logic [31:0] size_mask;
    logic [31:0] load_raw;

    // Lane shift, size mask and assembled load data for the latched access.
    always_comb begin
        sh = {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
`ifdef LSU_MISALIGNED_EN
        // Second word supplies the upper bytes of a split load.
        if (state_q == S_ACC1) begin
            load_raw = 32'({i_mem_rdata, buf_q} >> sh);
        end else begin
            load_raw = i_mem_rdata >> sh;
        end
`else
        load_raw = i_mem_rdata >> sh;
`endif
    end

    // Memory-side outputs, derived purely from state and latched request so
    // they stay stable while waiting for i_mem_ready.
    always_comb begin
        o_mem_valid = (state_q == S_ACC0) || (state_q == S_ACC1);
        o_mem_we    = store_q & o_mem_valid;
        o_mem_addr  = {addr_q[31:2], 2'b00};
        o_mem_mask  = 32'd0;
        o_mem_wdata = wdata_q << sh;
`ifdef LSU_MISALIGNED_EN
        // Upper halves of the 64-bit shifts are the bytes spilling into word+4.
        if (state_q == S_ACC1) begin
            o_mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
            o_mem_mask  = 32'(({32'd0, size_mask} << sh) >> 32);
            o_mem_wdata = 32'(({32'd0, wdata_q} << sh) >> 32);
        end else if (state_q == S_ACC0) begin
            o_mem_mask  = size_mask << sh;
        end
`else
        if (state_q == S_ACC0) begin
            o_mem_mask = size_mask << sh;
        end
`endif
    end

    // Next-state logic: request latch, access sequencing, response formation.
    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef LSU_MISALIGNED_EN
        buf_d      = buf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    store_d    = i_req_store;
                    size_d     = i_req_size;
                    uns_d      = i_req_unsigned;
                    addr_d     = i_req_addr;
                    wdata_d    = i_req_wdata;
                    rsp_data_d = 32'd0;
`ifdef LSU_MISALIGNED_EN
                    rsp_err_d  = (i_req_size == 2'd3);
`else
                    rsp_err_d  = (i_req_size == 2'd3) ||
                                 is_misaligned(i_req_size, i_req_addr[1:0]);
`endif
                    state_d    = rsp_err_d ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                if (i_mem_ready) begin
`ifdef LSU_MISALIGNED_EN
                    buf_d = i_mem_rdata;
                    if (is_misaligned(size_q, addr_q[1:0])) begin
                        state_d = S_ACC1;
                    end else begin
                        state_d    = S_RESP;
                        rsp_data_d = store_q ? 32'd0 : load_ext(load_raw, size_q, uns_q);
                    end
`else
                    state_d    = S_RESP;
                    rsp_data_d = store_q ? 32'd0 : load_ext(load_raw, size_q, uns_q);
`endif
                end
            end
`ifdef LSU_MISALIGNED_EN
            S_ACC1: begin
                if (i_mem_ready) begin
                    state_d    = S_RESP;
                    rsp_data_d = store_q ? 32'd0 : load_ext(load_raw, size_q, uns_q);
                end
            end
`endif
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d    = S_IDLE;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            buf_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef LSU_MISALIGNED_EN
            buf_q      <= buf_d;
`endif
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

endmodule
